// File: rtl/cache_port_arbiter.sv
// rtl/cache_port_arbiter.sv - zeroing sweep plus round-robin two-port arbiter for the single-port cache SRAM
module cache_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_DEPTH = 512,
  parameter int unsigned OUT_REGS   = 0
) (
  input  logic                       Clk_CI,
  input  logic                       Rst_RBI,
  input  logic [1:0]                 Req_SI,
  input  logic [1:0]                 WrEn_SI,
  input  logic [1:0][7:0]            BEn_SI,
  input  logic [1:0][ADDR_WIDTH-1:0] Addr_DI,
  input  logic [1:0][63:0]           WrData_DI,
  output logic [1:0]                 Gnt_SO,
  output logic [1:0]                 RValid_SO,
  output logic [63:0]                RData_DO,
  input  logic                       InitReq_SI,
  output logic                       InitDone_SO,
  output logic                       CSel_SO,
  output logic                       WrEn_SO,
  output logic [7:0]                 BEn_SO,
  output logic [ADDR_WIDTH-1:0]      Addr_DO,
  output logic [63:0]                WrData_DO,
  input  logic [63:0]                RdData_DI
);

  localparam int unsigned LAT = 1 + OUT_REGS;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DATA_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  last_gnt_q, last_gnt_d;
  logic [LAT-1:0]        sr_valid_q, sr_valid_d;
  logic [LAT-1:0]        sr_port_q, sr_port_d;
  logic                  init_done_q, init_done_d;

  logic sr_empty;
  logic sel;
  logic grant_en;

  // Round-robin pick: a tie goes to the port that did not win last time.
  always_comb begin
    sr_empty = (sr_valid_q == '0);
    sel      = (Req_SI == 2'b11) ? ~last_gnt_q : ~Req_SI[0];
    grant_en = (state_q == ST_RUN) && (Req_SI != 2'b00) && !(InitReq_SI && sr_empty);
    Gnt_SO   = 2'b00;
    if (grant_en) begin
      Gnt_SO[sel] = 1'b1;
    end
  end

  // SRAM port mux: sweep writes in INIT, the granted port in RUN, idle otherwise.
  always_comb begin
    CSel_SO   = 1'b0;
    WrEn_SO   = 1'b0;
    BEn_SO    = 8'h00;
    Addr_DO   = '0;
    WrData_DO = 64'd0;
    if (state_q == ST_INIT) begin
      CSel_SO = 1'b1;
      WrEn_SO = 1'b1;
      BEn_SO  = 8'hFF;
      Addr_DO = cnt_q;
    end else if (grant_en) begin
      CSel_SO   = 1'b1;
      WrEn_SO   = WrEn_SI[sel];
      BEn_SO    = BEn_SI[sel];
      Addr_DO   = Addr_DI[sel];
      WrData_DO = WrData_DI[sel];
    end
  end

  // Next state: sweep counter, re-init handling and drain of outstanding responses.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_gnt_d = grant_en ? sel : last_gnt_q;
    unique case (state_q)
      ST_INIT: begin
        if (cnt_q == LAST_ADDR) begin
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      ST_RUN: begin
        cnt_d = '0;
        if (InitReq_SI) begin
          state_d = sr_empty ? ST_INIT : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        cnt_d = '0;
        if (sr_empty) begin
          state_d = ST_INIT;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_INIT;
      end
    endcase
    init_done_d = (state_d == ST_RUN);
  end

  // Response pipeline: one {valid, port} slot per cycle of SRAM read latency.
  always_comb begin
    sr_valid_d    = sr_valid_q << 1;
    sr_port_d     = sr_port_q << 1;
    sr_valid_d[0] = grant_en;
    sr_port_d[0]  = sel;
    RValid_SO     = 2'b00;
    if (sr_valid_q[LAT-1]) begin
      RValid_SO[sr_port_q[LAT-1]] = 1'b1;
    end
  end

  assign RData_DO    = RdData_DI;
  assign InitDone_SO = init_done_q;

  // State register; reset discards any in-flight responses and restarts the sweep.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      last_gnt_q  <= 1'b1;
      sr_valid_q  <= '0;
      sr_port_q   <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_gnt_q  <= last_gnt_d;
      sr_valid_q  <= sr_valid_d;
      sr_port_q   <= sr_port_d;
      init_done_q <= init_done_d;
    end
  end

endmodule
